// File: rtl/lamp_frame_decoder_pkg.sv
// Shared constants and types for the lamp scan decoder.
package lamp_pkg;
  localparam int LAMP_COUNT  = 16;
  localparam int LAMP_ADDR_W = 4;

  typedef enum logic {HUNT, ASSEMBLE} lamp_dec_state_t;
endpackage

// File: rtl/lamp_frame_decoder_if.sv
// Lamp stream in, published frame and status out.
interface lamp_frame_decoder_if;
  import lamp_pkg::*;

  logic [LAMP_ADDR_W-1:0] encoder_in;
  logic                   enable_in;
  logic [LAMP_COUNT-1:0]  lamp_out;
  logic                   frame_done;
  logic                   seq_err;
  logic                   locked;

  modport master (
    output encoder_in, enable_in,
    input  lamp_out, frame_done, seq_err, locked
  );

  modport slave (
    input  encoder_in, enable_in,
    output lamp_out, frame_done, seq_err, locked
  );
endinterface

// File: rtl/lamp_frame_decoder_watchdog.sv
// Frame watchdog: saturating up-counter, expires when no kick arrives for TIMEOUT_CYCLES.
module lamp_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic kick,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (kick)
      cnt_d = '0;
    else if (cnt_q != LIMIT)
      cnt_d = cnt_q + 1'b1;
  end

  // Flags the edge on which the count lands on LIMIT; a kick on that edge wins.
  assign expired = !kick && (cnt_q == LIMIT - 1'b1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/lamp_frame_decoder.sv
// Rebuilds the 16-lamp vector from the (address, enable) stream and publishes whole frames.
//   state    | meaning
//   HUNT     | waiting for address 0 to start a frame
//   ASSEMBLE | collecting addresses in strict order into the shadow register
module lamp_frame_decoder
  import lamp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                 clk,
  input logic                 reset,
  lamp_frame_decoder_if.slave bus
);
  localparam logic [LAMP_ADDR_W-1:0] LAST_ADDR = LAMP_ADDR_W'(LAMP_COUNT - 1);

  lamp_dec_state_t        state_q, state_d;
  logic [LAMP_ADDR_W-1:0] expected_q, expected_d;
  logic [LAMP_COUNT-1:0]  shadow_q, shadow_d;
  logic [LAMP_COUNT-1:0]  lamp_q, lamp_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   locked_q, locked_d;
  logic                   wd_expired;

  logic [LAMP_ADDR_W-1:0] addr;
  logic                   en;

  assign addr = bus.encoder_in;
  assign en   = bus.enable_in;

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    shadow_d   = shadow_q;
    lamp_d     = lamp_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    locked_d   = locked_q;

    case (state_q)
      HUNT: begin
        if (addr == '0) begin
          shadow_d   = {{(LAMP_COUNT-1){1'b0}}, en};
          expected_d = LAMP_ADDR_W'(1);
          state_d    = ASSEMBLE;
        end
      end
      default: begin
        if (addr == expected_q) begin
          shadow_d[addr] = en;
          expected_d     = expected_q + 1'b1;
          if (addr == LAST_ADDR) begin
            lamp_d   = {en, shadow_q[LAMP_COUNT-2:0]};
            done_d   = 1'b1;
            locked_d = 1'b1;
          end
        end else begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          // A stray 0 is treated as a fresh frame start rather than a reason to hunt.
          if (addr == '0) begin
            shadow_d   = {{(LAMP_COUNT-1){1'b0}}, en};
            expected_d = LAMP_ADDR_W'(1);
          end else begin
            shadow_d   = '0;
            expected_d = '0;
            state_d    = HUNT;
          end
        end
      end
    endcase

    if (wd_expired) begin
      lamp_d   = '0;
      locked_d = 1'b0;
    end
  end

  lamp_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .kick    (done_d),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= HUNT;
      expected_q <= '0;
      shadow_q   <= '0;
      lamp_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      shadow_q   <= shadow_d;
      lamp_q     <= lamp_d;
      done_q     <= done_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.lamp_out   = lamp_q;
  assign bus.frame_done = done_q;
  assign bus.seq_err    = err_q;
  assign bus.locked     = locked_q;
endmodule

// File: tb/tb_lamp_frame_decoder.sv
// Directed and randomized stimulus for lamp_frame_decoder against a behavioural frame model.
module tb_lamp_frame_decoder;
  localparam int T = 64;

  logic clk;
  logic reset;
  lamp_frame_decoder_if bus();

  lamp_frame_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: next address wanted (-1 = hunting), collected lamps, cycles since last frame.
  int          m_next;
  logic [15:0] m_shadow;
  logic [15:0] m_lamp;
  logic        m_done, m_err, m_locked;
  int          m_idle;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_next = -1; m_shadow = '0; m_lamp = '0;
    m_done = 0; m_err = 0; m_locked = 0; m_idle = 0;
  endtask

  task automatic model_step(input int a, input logic e);
    bit frame;
    frame  = 0;
    m_done = 0;
    m_err  = 0;
    if (m_next < 0) begin
      if (a == 0) begin m_shadow = '0; m_shadow[0] = e; m_next = 1; end
    end else if (a == m_next) begin
      m_shadow[a] = e;
      if (a == 15) begin frame = 1; m_next = 0; end
      else m_next = m_next + 1;
    end else begin
      m_err = 1; m_locked = 0;
      if (a == 0) begin m_shadow = '0; m_shadow[0] = e; m_next = 1; end
      else m_next = -1;
    end
    if (frame) begin
      m_lamp = m_shadow; m_done = 1; m_locked = 1; m_idle = 0;
    end else if (m_idle < T) begin
      m_idle++;
      if (m_idle == T) begin m_lamp = '0; m_locked = 0; end
    end
  endtask

  task automatic compare_all(input string ph);
    chk({ph, ".lamp_out"},   bus.lamp_out,          m_lamp);
    chk({ph, ".frame_done"}, 16'(bus.frame_done),   16'(m_done));
    chk({ph, ".seq_err"},    16'(bus.seq_err),      16'(m_err));
    chk({ph, ".locked"},     16'(bus.locked),       16'(m_locked));
  endtask

  task automatic step(input string ph, input int a, input logic e);
    bus.encoder_in = 4'(a);
    bus.enable_in  = e;
    @(posedge clk);
    model_step(a, e);
    #1;
    compare_all(ph);
  endtask

  task automatic frame(input string ph, input logic [15:0] pat);
    for (int i = 0; i < 16; i++) step(ph, i, pat[i]);
  endtask

  initial begin
    int          dones;
    int          errs;
    int          lat;
    int          up;
    int          a;
    logic [15:0] pat;

    // 1. reset, then a stuck address
    reset = 1'b0;
    bus.encoder_in = 4'd0;
    bus.enable_in  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    reset = 1'b1;
    dones = 0; errs = 0;
    for (int i = 0; i < 20; i++) begin
      step("stuck5", 5, 1'b1);
      dones += int'(bus.frame_done);
      errs  += int'(bus.seq_err);
    end
    chk("stuck5.no_done", 16'(dones), 16'd0);
    chk("stuck5.no_err",  16'(errs),  16'd0);

    // 2. clean stream
    pat = 16'h0FA5;
    for (int f = 0; f < 3; f++) begin
      frame("clean", pat);
      chk("clean.lamp", bus.lamp_out, 16'h0FA5);
      chk("clean.done", 16'(bus.frame_done), 16'd1);
    end

    // 3. mid-frame start after reset
    reset = 1'b0; #1; model_reset(); reset = 1'b1;
    for (int i = 7; i < 16; i++) step("mid.skip", i, pat[i]);
    lat = 0;
    for (int i = 0; i < 16; i++) begin
      step("mid.frame", i, pat[i]);
      lat++;
      if (bus.frame_done) break;
    end
    chk("mid.latency", 16'(lat), 16'd16);

    // 4. skip and reload
    for (int i = 0; i <= 5; i++) step("skip", i, 1'b0);
    step("skip.bad", 7, 1'b1);
    chk("skip.err",    16'(bus.seq_err), 16'd1);
    chk("skip.locked", 16'(bus.locked),  16'd0);
    chk("skip.keep",   bus.lamp_out,     16'h0FA5);
    step("skip.after", 8, 1'b1);
    chk("skip.err_pulse", 16'(bus.seq_err), 16'd0);
    frame("reload", 16'h8001);
    chk("reload.lamp",   bus.lamp_out,     16'h8001);
    chk("reload.locked", 16'(bus.locked),  16'd1);

    // 5. stalled stream: watchdog expires T edges after the last frame_done
    frame("relock", pat);
    errs = 0;
    for (int i = 1; i <= 80; i++) begin
      step("stall", 3, 1'b1);
      errs += int'(bus.seq_err);
      if (i == T - 1) chk("stall.before", bus.lamp_out, 16'h0FA5);
      if (i == T)     chk("stall.blank",  bus.lamp_out, 16'h0000);
    end
    chk("stall.one_err", 16'(errs),        16'd1);
    chk("stall.lamp",    bus.lamp_out,     16'h0000);
    chk("stall.locked",  16'(bus.locked),  16'd0);

    // 6. asynchronous reset mid-frame
    frame("pre6", pat);
    for (int i = 0; i <= 9; i++) step("pre6.part", i, pat[i]);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    compare_all("async");
    @(posedge clk); #1;
    compare_all("async.hold");
    reset = 1'b1;
    dones = 0;
    for (int i = 10; i < 16; i++) begin
      step("async.tail", i, pat[i]);
      dones += int'(bus.frame_done);
    end
    chk("async.no_done", 16'(dones), 16'd0);
    frame("async.full", pat);
    chk("async.done", 16'(bus.frame_done), 16'd1);
    chk("async.lamp", bus.lamp_out,        16'h0FA5);

    // randomized stream: mostly ordered, with glitches, new patterns and one long stall
    up  = 0;
    pat = 16'($urandom);
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        for (int s = 0; s < T + 10; s++) step("rand.stall", 9, 1'b0);
      end
      if ($urandom_range(0, 99) < 6) a = int'($urandom_range(0, 15));
      else a = up;
      step("rand", a, pat[a]);
      up = (a + 1) % 16;
      if (a == 15) pat = 16'($urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
